// File: rtl/wb_regfile_pkg.sv
// Shared register-file constants and types for the MEM/WB and ID stages.
package wb_regfile_pkg;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = $clog2(REG_NUM);
    localparam int WORD_W     = 32;
    localparam int PEND_W     = 2;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [PEND_W-1:0]     PEND_MAX = '1;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [PEND_W-1:0]     pend_cnt_t;
endpackage

// File: rtl/wb_regfile_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register, set at ID issue, cleared at WB.
// REGFILE_BYPASS_EN adds the single-pending flags the top uses to hide a retiring write.
module wb_scoreboard
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wb_regDest,
    input  logic                  id_issue,
    input  logic [REG_ADDR_W-1:0] id_issueDest,
    input  logic [REG_ADDR_W-1:0] id_raddr1,
    input  logic [REG_ADDR_W-1:0] id_raddr2,
    output logic                  id_issueReady,
    output logic                  raw_busy1,
    output logic                  raw_busy2
`ifdef REGFILE_BYPASS_EN
    ,
    output logic                  last_pend1,
    output logic                  last_pend2
`endif
);
    pend_cnt_t          cnt_q [REG_NUM];
    pend_cnt_t          cnt_d [REG_NUM];
    logic [REG_NUM-1:0] inc_vec;
    logic [REG_NUM-1:0] dec_vec;

    always_comb begin
        id_issueReady = (id_issueDest == ZERO_REG) || (cnt_q[id_issueDest] != PEND_MAX);
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (id_issue && id_issueReady && id_issueDest != ZERO_REG)
            inc_vec[id_issueDest] = 1'b1;
        if (wb_regDest != ZERO_REG)
            dec_vec[wb_regDest] = 1'b1;
    end

    // A retirement with nothing pending is a protocol error; clamp instead of wrapping.
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r])
                cnt_d[r] = cnt_q[r] + 1'b1;
            else if (!inc_vec[r] && dec_vec[r] && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++)
                cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wb_regDest != ZERO_REG)
            assert (cnt_q[wb_regDest] != '0);
    end

    always_comb begin
        raw_busy1 = (id_raddr1 != ZERO_REG) && (cnt_q[id_raddr1] != '0);
        raw_busy2 = (id_raddr2 != ZERO_REG) && (cnt_q[id_raddr2] != '0);
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        last_pend1 = (cnt_q[id_raddr1] == pend_cnt_t'(1));
        last_pend2 = (cnt_q[id_raddr2] == pend_cnt_t'(1));
    end
`endif
endmodule

// File: rtl/wb_regfile.sv
// Architectural register file at the WB end: one write, two combinational reads, RAW scoreboard.
// Define REGFILE_BYPASS_EN for write-first bypass of a same-cycle writeback to the read ports.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wb_regDest,
    input  logic [WORD_W-1:0]     wb_result,
    input  logic [REG_ADDR_W-1:0] id_raddr1,
    input  logic [REG_ADDR_W-1:0] id_raddr2,
    output logic [WORD_W-1:0]     id_rdata1,
    output logic [WORD_W-1:0]     id_rdata2,
    output logic                  id_busy1,
    output logic                  id_busy2,
    input  logic                  id_issue,
    input  logic [REG_ADDR_W-1:0] id_issueDest,
    output logic                  id_issueReady
);
    word_t regs_q [REG_NUM];
    word_t regs_d [REG_NUM];
    word_t stored1;
    word_t stored2;
    logic  raw_busy1;
    logic  raw_busy2;

    always_comb begin
        regs_d = regs_q;
        if (wb_regDest != ZERO_REG)
            regs_d[wb_regDest] = wb_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++)
                regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        stored1 = (id_raddr1 == ZERO_REG) ? '0 : regs_q[id_raddr1];
        stored2 = (id_raddr2 == ZERO_REG) ? '0 : regs_q[id_raddr2];
    end

`ifdef REGFILE_BYPASS_EN
    logic last_pend1;
    logic last_pend2;
    logic hit1;
    logic hit2;

    wb_scoreboard u_sb (
        .clk           (clk),
        .rst           (rst),
        .wb_regDest    (wb_regDest),
        .id_issue      (id_issue),
        .id_issueDest  (id_issueDest),
        .id_raddr1     (id_raddr1),
        .id_raddr2     (id_raddr2),
        .id_issueReady (id_issueReady),
        .raw_busy1     (raw_busy1),
        .raw_busy2     (raw_busy2),
        .last_pend1    (last_pend1),
        .last_pend2    (last_pend2)
    );

    // The retiring write is visible now; busy only if another write is still behind it.
    always_comb begin
        hit1      = (wb_regDest != ZERO_REG) && (wb_regDest == id_raddr1);
        hit2      = (wb_regDest != ZERO_REG) && (wb_regDest == id_raddr2);
        id_rdata1 = hit1 ? wb_result : stored1;
        id_rdata2 = hit2 ? wb_result : stored2;
        id_busy1  = raw_busy1 && !(hit1 && last_pend1);
        id_busy2  = raw_busy2 && !(hit2 && last_pend2);
    end
`else
    wb_scoreboard u_sb (
        .clk           (clk),
        .rst           (rst),
        .wb_regDest    (wb_regDest),
        .id_issue      (id_issue),
        .id_issueDest  (id_issueDest),
        .id_raddr1     (id_raddr1),
        .id_raddr2     (id_raddr2),
        .id_issueReady (id_issueReady),
        .raw_busy1     (raw_busy1),
        .raw_busy2     (raw_busy2)
    );

    always_comb begin
        id_rdata1 = stored1;
        id_rdata2 = stored2;
        id_busy1  = raw_busy1;
        id_busy2  = raw_busy2;
    end
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: per-cycle comparison against a behavioural model plus literal checks.
module tb_wb_regfile;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int NREG = 32;
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  wb_regDest = '0;
    logic [31:0] wb_result = '0;
    logic [4:0]  id_raddr1 = '0;
    logic [4:0]  id_raddr2 = '0;
    logic [31:0] id_rdata1;
    logic [31:0] id_rdata2;
    logic        id_busy1;
    logic        id_busy2;
    logic        id_issue = 1'b0;
    logic [4:0]  id_issueDest = '0;
    logic        id_issueReady;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [NREG];
    int          m_cnt  [NREG];
    bit          m_valid = 1'b0;

    wb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .wb_regDest    (wb_regDest),
        .wb_result     (wb_result),
        .id_raddr1     (id_raddr1),
        .id_raddr2     (id_raddr2),
        .id_rdata1     (id_rdata1),
        .id_rdata2     (id_rdata2),
        .id_busy1      (id_busy1),
        .id_busy2      (id_busy2),
        .id_issue      (id_issue),
        .id_issueDest  (id_issueDest),
        .id_issueReady (id_issueReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (id_issueDest == 0) || (m_cnt[id_issueDest] < CMAX);
    endfunction

    function automatic int next_cnt(input int r);
        int c;
        c = m_cnt[r];
        if (id_issue && m_ready() && id_issueDest == r) c = c + 1;
        if (wb_regDest == r) c = c - 1;
        if (c < 0) c = 0;
        return c;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && wb_regDest == a) return wb_result;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (BYP && wb_regDest == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] <= '0;
                m_cnt[r]  <= 0;
            end
            m_valid <= 1'b1;
        end else if (m_valid) begin
            for (int r = 1; r < NREG; r++)
                m_cnt[r] <= next_cnt(r);
            if (wb_regDest != 0)
                m_regs[wb_regDest] <= wb_result;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_rdata1", id_rdata1, exp_rdata(id_raddr1));
            chk("cmp_rdata2", id_rdata2, exp_rdata(id_raddr2));
            chk("cmp_busy1", {31'b0, id_busy1}, {31'b0, exp_busy(id_raddr1)});
            chk("cmp_busy2", {31'b0, id_busy2}, {31'b0, exp_busy(id_raddr2)});
            chk("cmp_ready", {31'b0, id_issueReady}, {31'b0, m_ready()});
        end
    end

    task automatic drive(input logic r, input logic iss, input logic [4:0] idst,
                         input logic [4:0] wd, input logic [31:0] wr,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        rst = r; id_issue = iss; id_issueDest = idst;
        wb_regDest = wd; wb_result = wr; id_raddr1 = a1; id_raddr2 = a2;
        #3;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // reset state
        drive(0, 0, 1, 0, 0, 1, 31);
        chk("rst_rd1", id_rdata1, 32'h0);
        chk("rst_rd2", id_rdata2, 32'h0);
        chk("rst_b1", {31'b0, id_busy1}, 32'd0);
        chk("rst_b2", {31'b0, id_busy2}, 32'd0);
        chk("rst_rdy", {31'b0, id_issueReady}, 32'd1);

        // issue r5, retire three cycles later
        drive(0, 1, 5, 0, 0, 5, 0);
        chk("r5_c0_b1", {31'b0, id_busy1}, 32'd0);
        drive(0, 0, 0, 0, 0, 5, 0);
        chk("r5_c1_b1", {31'b0, id_busy1}, 32'd1);
        drive(0, 0, 0, 0, 0, 5, 0);
        chk("r5_c2_b1", {31'b0, id_busy1}, 32'd1);
        drive(0, 0, 0, 5, 32'hDEADBEEF, 5, 0);
        chk("r5_c3_b1", {31'b0, id_busy1}, BYP ? 32'd0 : 32'd1);
        chk("r5_c3_rd1", id_rdata1, BYP ? 32'hDEADBEEF : 32'h0);
        drive(0, 0, 0, 0, 0, 5, 0);
        chk("r5_c4_rd1", id_rdata1, 32'hDEADBEEF);
        chk("r5_c4_b1", {31'b0, id_busy1}, 32'd0);

        // register 0 is inert
        drive(0, 1, 0, 0, 32'h12345678, 0, 0);
        chk("r0_rd1", id_rdata1, 32'h0);
        chk("r0_b1", {31'b0, id_busy1}, 32'd0);
        chk("r0_rdy", {31'b0, id_issueReady}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r0_rd1_after", id_rdata1, 32'h0);

        // saturate r7
        drive(0, 1, 7, 0, 0, 7, 0);
        drive(0, 1, 7, 0, 0, 7, 0);
        drive(0, 1, 7, 0, 0, 7, 0);
        chk("r7_rdy_cnt2", {31'b0, id_issueReady}, 32'd1);
        drive(0, 1, 7, 0, 0, 7, 0);
        chk("r7_rdy_sat", {31'b0, id_issueReady}, 32'd0);
        drive(0, 0, 7, 7, 32'h77, 7, 0);
        chk("r7_rdy_still_sat", {31'b0, id_issueReady}, 32'd0);
        drive(0, 0, 7, 0, 0, 7, 0);
        chk("r7_rdy_after_wb", {31'b0, id_issueReady}, 32'd1);
        chk("r7_b1_cnt2", {31'b0, id_busy1}, 32'd1);
        chk("r7_rd1", id_rdata1, 32'h77);
        drive(0, 0, 7, 7, 32'h78, 7, 0);
        drive(0, 0, 7, 0, 0, 7, 0);
        chk("r7_b1_cnt1", {31'b0, id_busy1}, 32'd1);
        drive(0, 0, 7, 7, 32'h79, 7, 0);
        drive(0, 0, 7, 0, 0, 7, 0);
        chk("r7_b1_cnt0", {31'b0, id_busy1}, 32'd0);
        chk("r7_rd1_last", id_rdata1, 32'h79);

        // simultaneous issue and retire on r9
        drive(0, 1, 9, 0, 0, 9, 0);
        drive(0, 1, 9, 9, 32'hA5A5A5A5, 9, 0);
        chk("r9_same_rd1", id_rdata1, BYP ? 32'hA5A5A5A5 : 32'h0);
        chk("r9_same_b1", {31'b0, id_busy1}, BYP ? 32'd0 : 32'd1);
        drive(0, 0, 0, 0, 0, 9, 0);
        chk("r9_b1_after", {31'b0, id_busy1}, 32'd1);
        chk("r9_rd1_after", id_rdata1, 32'hA5A5A5A5);
        drive(0, 0, 0, 9, 32'h0, 9, 0);
        drive(0, 0, 0, 0, 0, 9, 0);
        chk("r9_b1_clear", {31'b0, id_busy1}, 32'd0);

        // mid-run reset discards data and pending state
        drive(0, 1, 3, 0, 0, 0, 0);
        drive(0, 1, 4, 3, 32'h1111, 3, 4);
        drive(0, 0, 0, 4, 32'h2222, 3, 4);
        drive(0, 0, 0, 0, 0, 3, 4);
        chk("r34_rd1", id_rdata1, 32'h1111);
        chk("r34_rd2", id_rdata2, 32'h2222);
        drive(0, 1, 3, 0, 0, 3, 4);
        drive(0, 1, 4, 0, 0, 3, 4);
        drive(0, 0, 0, 0, 0, 3, 4);
        chk("r34_b1_pend", {31'b0, id_busy1}, 32'd1);
        chk("r34_b2_pend", {31'b0, id_busy2}, 32'd1);
        drive(1, 0, 0, 3, 32'hFFFF, 3, 4);
        drive(0, 0, 3, 0, 0, 3, 4);
        chk("rst2_rd1", id_rdata1, 32'h0);
        chk("rst2_rd2", id_rdata2, 32'h0);
        chk("rst2_b1", {31'b0, id_busy1}, 32'd0);
        chk("rst2_b2", {31'b0, id_busy2}, 32'd0);
        chk("rst2_rdy", {31'b0, id_issueReady}, 32'd1);

        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural general-purpose register file at the consuming end of the MEM/WB writeback interface.
- Accepts one writeback per cycle (wb_regDest, wb_result) from the MEM/WB pipeline register.
- Serves two combinational read ports to the ID stage.
- Holds a per-register pending-write scoreboard: ID marks a destination busy at issue, WB clears it on retirement. ID uses the busy flags to stall on RAW hazards.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 hardwired to zero.
- REG_ADDR_W, 5, address width; equals clog2(REG_NUM).
- WORD_W, 32, data width.
- PEND_W, 2, width of each per-register pending-write counter; max in flight per register = 2^PEND_W-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- wb_regDest  in  REG_ADDR_W  writeback destination; 0 = no write.
- wb_result  in  WORD_W  writeback data.
- id_raddr1  in  REG_ADDR_W  read port 1 address.
- id_raddr2  in  REG_ADDR_W  read port 2 address.
- id_rdata1  out  WORD_W  read port 1 data (combinational).
- id_rdata2  out  WORD_W  read port 2 data (combinational).
- id_busy1  out  1  register at id_raddr1 has a pending write not covered by same-cycle writeback.
- id_busy2  out  1  same for id_raddr2.
- id_issue  in  1  ID issues an instruction that will write id_issueDest.
- id_issueDest  in  REG_ADDR_W  destination of the issuing instruction; 0 = no scoreboard effect.
- id_issueReady  out  1  low when the pending counter of id_issueDest is saturated; ID must not issue.

Behaviour:
- Reset: all registers = 0; all pending counters = 0. Consequently id_rdata*=0, id_busy*=0, id_issueReady=1 in the first cycle after reset.
- Write: at posedge, when wb_regDest!=0, reg[wb_regDest] <= wb_result. Writes to register 0 are dropped; reg[0] always reads 0.
- Read: combinational, zero latency. Address 0 always returns 0 and busy 0.
- Scoreboard, per register r != 0, at each posedge:
  - inc = id_issue && id_issueReady && id_issueDest==r
  - dec = wb_regDest==r
  - cnt <= cnt + inc - dec
  - inc && dec in the same cycle: cnt unchanged.
  - dec with cnt==0 is a protocol error: cnt stays 0 (no wrap); a simulation assertion fires.
- id_issueReady = !(cnt[id_issueDest]==2^PEND_W-1) || id_issueDest==0. id_issue while not ready is ignored.
- id_busyN = (cnt[id_raddrN] != 0) && id_raddrN != 0, evaluated after discounting a same-cycle writeback per REGFILE_BYPASS_EN.
- Read of a register being issued in the same cycle: returns the old value; busy reflects the pre-issue count. The issuing instruction does not self-stall.
- rst asserted mid-operation: all in-flight pending state is discarded; WB inputs in the rst cycle are ignored.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-first bypass. When wb_regDest!=0 and wb_regDest==id_raddrN, id_rdataN = wb_result in the same cycle.
  - If that writeback is the register's only pending write (cnt==1, no other pending), id_busyN = 0.
  - WB-to-ID hazard costs 0 stall cycles.
- Undefined:
  - Read returns the stored value.
  - id_busyN remains 1 in the writeback cycle; the ID stage stalls one extra cycle and reads the written value after the posedge.

Decomposition:
- Shared package: REG_ADDR_W, WORD_W, REG_NUM, ZERO_REG constant (0), word/address typedefs, shared with the MEM_WB and ID stages.
- One natural sub-module: wb_scoreboard, holding the pending counter array, id_issueReady and raw busy flags.
- Register array, read muxes and bypass logic stay in the top module.

Test Plan:
- Reset then read r1, r31 -> rdata=0, busy=0, issueReady=1.
- Issue r5 (cycle 0); WB r5=0xDEADBEEF at cycle 3 -> busy1=1 cycles 1-2.
  - Bypass on: cycle 3 rdata1=0xDEADBEEF, busy1=0.
  - Bypass off: cycle 3 busy1=1; cycle 4 rdata1=0xDEADBEEF, busy1=0.
- WB r0=0x12345678; issue r0 -> r0 reads 0, busy 0, issueReady stays 1.
- Issue r7 three times with no WB (PEND_W=2) -> issueReady=0; fourth issue ignored; one WB r7 -> issueReady=1, counter 2.
- Simultaneous issue r9 and WB r9=0xA5A5A5A5 with cnt=1 -> cnt stays 1, busy stays 1, reg=0xA5A5A5A5.
- Issue r3, r4, then assert rst one cycle -> all busy=0, r3/r4 read 0, issueReady=1.
